// File: rtl/time_base_multi_if.sv
// Bus bundle for the multi-channel timebase: per-channel programming, control
// and interrupt status. The controller uses master; the timebase uses slave.
interface time_base_multi_if #(
    parameter int CH_NUM = 4,
    parameter int CNT_W  = 32
);
    logic [CH_NUM*CNT_W-1:0] PROG_INT;
    logic [CH_NUM-1:0]       CH_EN;
    logic [CH_NUM-1:0]       ONE_SHOT;
    logic [CH_NUM-1:0]       START;
    logic [CH_NUM-1:0]       INT_ACK;
    logic [CH_NUM-1:0]       INT_ENABLE;
    logic [CH_NUM-1:0]       INT_PEND;
    logic [CH_NUM-1:0]       INT_OVR;
    logic                    INT_ANY;

    modport master (
        output PROG_INT, CH_EN, ONE_SHOT, START, INT_ACK,
        input  INT_ENABLE, INT_PEND, INT_OVR, INT_ANY
    );

    modport slave (
        input  PROG_INT, CH_EN, ONE_SHOT, START, INT_ACK,
        output INT_ENABLE, INT_PEND, INT_OVR, INT_ANY
    );
endinterface

// File: rtl/time_base_multi.sv
// Multi-channel programmable timebase: per-channel periodic or one-shot
// down-counters with one-cycle ticks, sticky pending and overrun flags.
module time_base_multi #(
    parameter int CH_NUM = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    time_base_multi_if.slave  bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e            state_q [CH_NUM];
    state_e            state_d [CH_NUM];
    logic [CNT_W-1:0]  cnt_q   [CH_NUM];
    logic [CNT_W-1:0]  cnt_d   [CH_NUM];
    logic [CNT_W-1:0]  prog    [CH_NUM];
    logic [CH_NUM-1:0] tick_q, tick_d;
    logic [CH_NUM-1:0] pend_q, pend_d;
    logic [CH_NUM-1:0] ovr_q,  ovr_d;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_prog
        assign prog[g] = bus.PROG_INT[g*CNT_W +: CNT_W];
    end

    // NOTE: state registers use non-blocking assignments so every channel
    // samples the pre-edge values; blocking here would create order races.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CH_NUM; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            tick_q <= '0;
            pend_q <= '0;
            ovr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
        end
    end

    // NOTE: every output of this block gets a default before any branch,
    // otherwise an unassigned path would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_d  = '0;
        pend_d  = pend_q;
        ovr_d   = ovr_q;

        for (int i = 0; i < CH_NUM; i++) begin
            if (!bus.CH_EN[i]) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
            end else if (state_q[i] == IDLE) begin
                if (bus.START[i] || !bus.ONE_SHOT[i]) begin
                    state_d[i] = RUN;
                    cnt_d[i]   = prog[i];
                end
            end else if (cnt_q[i] == '0) begin
                tick_d[i] = 1'b1;
                // A retrigger on the terminal keeps even a one-shot channel running.
                if (bus.START[i] || !bus.ONE_SHOT[i]) begin
                    cnt_d[i] = prog[i];
                end else begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            end else if (bus.START[i]) begin
                cnt_d[i] = prog[i];
            end else begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end

            // Set wins over acknowledge; an acked tick starts a fresh overrun window.
            if (tick_d[i]) begin
                pend_d[i] = 1'b1;
                if (bus.INT_ACK[i])
                    ovr_d[i] = 1'b0;
                else if (pend_q[i])
                    ovr_d[i] = 1'b1;
            end else if (bus.INT_ACK[i]) begin
                pend_d[i] = 1'b0;
                ovr_d[i]  = 1'b0;
            end
        end
    end

    assign bus.INT_ENABLE = tick_q;
    assign bus.INT_PEND   = pend_q;
    assign bus.INT_OVR    = ovr_q;
    assign bus.INT_ANY    = |pend_q;
endmodule

// File: tb/tb_time_base_multi.sv
// Directed bench for time_base_multi: a 4x32 instance and a 1x8 instance
// sharing clock and reset, with hand-computed tick positions.
module tb_time_base_multi;
    localparam int CNT_W = 32;

    logic clock;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    time_base_multi_if #(.CH_NUM(4), .CNT_W(32)) bus ();
    time_base_multi_if #(.CH_NUM(1), .CNT_W(8))  bus1 ();

    time_base_multi #(.CH_NUM(4), .CNT_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    time_base_multi #(.CH_NUM(1), .CNT_W(8)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_p(input int ch, input logic [31:0] val);
        bus.PROG_INT[ch*CNT_W +: CNT_W] = val;
    endtask

    task automatic quiesce();
        bus.CH_EN     = '0;
        bus.START     = '0;
        bus.ONE_SHOT  = '0;
        bus.INT_ACK   = '1;
        bus1.CH_EN    = '0;
        bus1.START    = '0;
        bus1.ONE_SHOT = '0;
        bus1.INT_ACK  = '1;
        cyc();
        bus.INT_ACK  = '0;
        bus1.INT_ACK = '0;
        cyc();
        check("quiesce", 32'({bus.INT_ENABLE, bus.INT_PEND, bus.INT_OVR, bus1.INT_PEND}), 32'd0);
    endtask

    function automatic logic [31:0] all_out();
        return 32'({bus.INT_ENABLE, bus.INT_PEND, bus.INT_OVR, bus.INT_ANY,
                    bus1.INT_ENABLE, bus1.INT_PEND, bus1.INT_OVR, bus1.INT_ANY});
    endfunction

    initial begin
        bus.PROG_INT  = '0;
        bus.CH_EN     = '0;
        bus.ONE_SHOT  = '0;
        bus.START     = '0;
        bus.INT_ACK   = '0;
        bus1.PROG_INT = '0;
        bus1.CH_EN    = '0;
        bus1.ONE_SHOT = '0;
        bus1.START    = '0;
        bus1.INT_ACK  = '0;

        // Reset and idle
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 check("rst_async", all_out(), 32'd0);
        repeat (3) cyc();
        check("rst_hold", all_out(), 32'd0);
        reset = 1'b1;
        for (int j = 0; j < 100; j++) begin
            cyc();
            check("idle", all_out(), 32'd0);
        end

        // Periodic ch0 P=4: ticks 5 edges apart after the arming edge
        set_p(0, 4);
        bus.CH_EN[0] = 1'b1;
        cyc();
        for (int j = 1; j <= 19; j++) begin
            cyc();
            check("per_p4", 32'(bus.INT_ENABLE[0]), 32'(j % 5 == 0));
        end
        check("ovr_pend", 32'(bus.INT_PEND[0]), 32'd1);
        check("ovr_set", 32'(bus.INT_OVR[0]), 32'd1);
        check("ovr_any", 32'(bus.INT_ANY), 32'd1);
        bus.INT_ACK[0] = 1'b1;
        cyc();
        bus.INT_ACK[0] = 1'b0;
        check("ack_tick_en", 32'(bus.INT_ENABLE[0]), 32'd1);
        check("ack_tick_pend", 32'(bus.INT_PEND[0]), 32'd1);
        check("ack_tick_ovr", 32'(bus.INT_OVR[0]), 32'd0);
        bus.INT_ACK[0] = 1'b1;
        cyc();
        bus.INT_ACK[0] = 1'b0;
        check("ack_lone_pend", 32'(bus.INT_PEND[0]), 32'd0);
        check("ack_lone_ovr", 32'(bus.INT_OVR[0]), 32'd0);
        check("ack_lone_any", 32'(bus.INT_ANY), 32'd0);
        quiesce();

        // Periodic ch1 P=0: tick every clock; disable keeps the flags
        set_p(1, 0);
        bus.CH_EN[1] = 1'b1;
        cyc();
        for (int j = 1; j <= 5; j++) begin
            cyc();
            check("per_p0", 32'(bus.INT_ENABLE[1]), 32'd1);
        end
        bus.CH_EN[1] = 1'b0;
        cyc();
        check("dis_tick", 32'(bus.INT_ENABLE[1]), 32'd0);
        check("dis_pend", 32'(bus.INT_PEND[1]), 32'd1);
        check("dis_ovr", 32'(bus.INT_OVR[1]), 32'd1);
        quiesce();

        // One-shot ch2 P=9
        set_p(2, 9);
        bus.ONE_SHOT[2] = 1'b1;
        bus.CH_EN[2]    = 1'b1;
        for (int j = 0; j < 3; j++) begin
            cyc();
            check("os_noauto", 32'(bus.INT_ANY), 32'd0);
        end
        bus.START[2] = 1'b1;
        cyc();
        bus.START[2] = 1'b0;
        for (int j = 1; j <= 15; j++) begin
            cyc();
            check("os_single", 32'(bus.INT_ENABLE[2]), 32'(j == 10));
        end
        check("os_pend", 32'(bus.INT_PEND[2]), 32'd1);
        check("os_ovr0", 32'(bus.INT_OVR[2]), 32'd0);
        for (int j = 0; j <= 20; j++) begin
            if (j == 0 || j == 5) bus.START[2] = 1'b1;
            cyc();
            bus.START[2] = 1'b0;
            if (j > 0) check("os_retrig", 32'(bus.INT_ENABLE[2]), 32'(j == 15));
        end
        check("os_ovr1", 32'(bus.INT_OVR[2]), 32'd1);
        for (int j = 0; j <= 25; j++) begin
            if (j == 0 || j == 10) bus.START[2] = 1'b1;
            cyc();
            bus.START[2] = 1'b0;
            if (j > 0) check("os_term_start", 32'(bus.INT_ENABLE[2]), 32'(j == 10 || j == 20));
        end
        quiesce();

        // Reload: P=7 changed to 2 mid-count
        set_p(0, 7);
        bus.CH_EN[0] = 1'b1;
        cyc();
        for (int j = 1; j <= 15; j++) begin
            if (j == 3) set_p(0, 2);
            cyc();
            check("reload", 32'(bus.INT_ENABLE[0]), 32'(j == 8 || j == 11 || j == 14));
        end
        quiesce();

        // Mode change in RUN takes effect at the next terminal
        set_p(3, 3);
        bus.CH_EN[3] = 1'b1;
        cyc();
        for (int j = 1; j <= 10; j++) begin
            if (j == 2) bus.ONE_SHOT[3] = 1'b1;
            cyc();
            check("mode_chg", 32'(bus.INT_ENABLE[3]), 32'(j == 4));
        end
        quiesce();

        // Disable on the terminal cycle suppresses the tick; START ignored when disabled
        set_p(0, 3);
        bus.CH_EN[0] = 1'b1;
        cyc();
        for (int j = 1; j <= 6; j++) begin
            if (j == 4) bus.CH_EN[0] = 1'b0;
            cyc();
            check("dis_term", 32'(bus.INT_ENABLE[0]), 32'd0);
        end
        check("dis_term_pend", 32'(bus.INT_PEND[0]), 32'd0);
        bus.START[0] = 1'b1;
        cyc();
        bus.START[0] = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            cyc();
            check("dis_start", 32'(bus.INT_ENABLE[0]), 32'd0);
        end
        quiesce();

        // Async reset mid-count on both builds
        set_p(3, 1);
        bus.CH_EN[3]  = 1'b1;
        bus1.PROG_INT = 8'd3;
        bus1.CH_EN    = 1'b1;
        cyc();
        for (int j = 1; j <= 5; j++) cyc();
        check("pre_rst_pend", 32'(bus.INT_PEND[3]), 32'd1);
        check("pre_rst_pend1", 32'(bus1.INT_PEND), 32'd1);
        #2 reset = 1'b0;
        #1 check("rst_mid", all_out(), 32'd0);
        #2 reset = 1'b1;
        for (int j = 0; j <= 5; j++) begin
            cyc();
            check("rst_rel", 32'(bus.INT_ENABLE[3]), 32'(j == 2 || j == 4));
            check("rst_rel1", 32'(bus1.INT_ENABLE), 32'(j == 4));
        end
        quiesce();

        // Narrow build: full-scale one-shot period
        bus1.PROG_INT = 8'hFF;
        bus1.ONE_SHOT = 1'b1;
        bus1.CH_EN    = 1'b1;
        bus1.START    = 1'b1;
        cyc();
        bus1.START = 1'b0;
        for (int j = 1; j <= 260; j++) begin
            cyc();
            check("w8_max", 32'(bus1.INT_ENABLE), 32'(j == 256));
        end
        check("w8_pend", 32'(bus1.INT_PEND), 32'd1);
        check("w8_ovr", 32'(bus1.INT_OVR), 32'd0);
        check("w8_any", 32'(bus1.INT_ANY), 32'd1);
        quiesce();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
